stream_dma_write: RTL
=====================

// Module: stream_dma_write
// PURPOSE
//  Frame-write DMA, downstream of the pixel-stream DMA read stage: consumes a PW-bit pixel stream,
//  packs DW/PW pixels per word, buffers words in a FIFO, and writes them to memory as Avalon-style
//  write bursts through one write port of xlib_avalon_bus. CPU-programmed via cpb regs; irq on frame done.
// PARAMETERS
//  WIDTH    1280    pixels per line; WIDTH*PW must be a multiple of DW
//  PW       8       pixel width, bits; DW % PW == 0
//  AW       32      bus address width (word address)
//  DW       32      bus data width
//  BL       4       burst length field width; max burst = 2**BL-1 words
//  FIFO_AW  5       word FIFO depth = 2**FIFO_AW; must be >= 2**BL
//  APB_AW   5       cpb address width
//  ID       32'hCE6 value returned by IDR
// PORTS
//  clk           in   1        clock
//  rst_n         in   1        reset
//  cpb_r         in   1        register read strobe (unused; reads are combinational)
//  cpb_w         in   1        register write strobe, one cycle
//  cpb_a         in   APB_AW   register index
//  cpb_d         in   32       write data
//  cpb_q         out  32       read data, combinational mux on cpb_a
//  irq           out  1        = SR[0]
//  src_str_rdy   out  1        pixel accepted when src_str_val && src_str_rdy
//  src_str_val   in   1        pixel valid
//  src_str_d     in   PW       pixel data
//  dst_bus_wrdy  in   1        beat accepted when dst_bus_wval && dst_bus_wrdy
//  dst_bus_wval  out  1        write beat valid
//  dst_bus_wlen  out  BL       burst length, words; constant for whole burst
//  dst_bus_waddr out  AW       burst start word address; constant for whole burst
//  dst_bus_wdata out  DW       beat data
// BEHAVIOUR
//  Reset: rst_n, asynchronous, active-high; clock clk. All regs, FIFO pointers, packer and FSM clear;
//   outputs reset to 0 (cpb_q = mux of cleared regs, IDR still reads ID).
//  Registers: 0 IDR ro ID | 1 CR bit0 EN | 2 SR bit0 DONE, write-1-to-clear | 3 DA start word address
//   | 4 LR line count | 5 BURSTR burst words (0 treated as 1). Total words T = LR*WIDTH*PW/DW.
//  Start: CR write with bit0=1 in IDLE latches DA,BURSTR,T into working regs; writes to DA/LR/BURSTR
//   while busy update the register only, not the running transfer.
//  Packer: pixel k of a word lands in bits [k*PW +: PW], first pixel at LSBs; word pushed to FIFO
//   on accept of its last pixel. src_str_rdy = busy && !fifo_full && pixels_taken < T*DW/PW;
//   pixels beyond frame are never accepted.
//  FSM IDLE -> WAIT on start. WAIT -> BURST when fifo_count >= n, n = min(BURSTR, words_left);
//   drive wlen=n, waddr=cur_addr, wval=1, wdata=FIFO head (first-word fall-through).
//  BURST: each accepted beat pops FIFO; wval stays high, no bubbles, while data present (guaranteed by
//   WAIT threshold). After n-th beat: cur_addr += n, words_left -= n; words_left==0 -> DONE else WAIT.
//  DONE: set SR[0] (irq rises the cycle after last beat), clear busy -> IDLE. Re-arm needs a new CR write.
//  CR bit0 cleared while busy (abort): current burst completes, then FIFO and packer flush,
//   -> IDLE, DONE not set.
//  Simultaneous SR W1C and DONE set in the same cycle: set wins.
//  Address arithmetic AW-bit, wraps modulo 2**AW with no error. T==0 (LR=0): DONE the cycle after start.
//  Full FIFO: stream stalls (rdy=0); empty FIFO never reaches BURST.
// STRUCTURE
//  Package stream_dma_write_pkg: register index localparams (IDR..BURSTR), FSM enum
//   {IDLE,WAIT,BURST,DONE}, SR/CR bit positions.
//  Sub-module: xlib_sync_fifo (DW wide, 2**FIFO_AW deep, fall-through, count output).
//  Top holds cpb regs, packer, FSM, burst counters; ~250 lines.
// TESTING
//  1 Reset: after rst_n pulse, IDR reads 32'hCE6, all other regs 0, wval=0, irq=0, src_str_rdy=0.
//  2 Frame: DA=32'h2000, LR=64, BURSTR=2, pixels (i%256) continuous, wrdy always 1 -> 20480 words at
//   2000h..6FFFh, word0=32'h03020100, 10240 bursts of len 2, irq once after last beat.
//  3 Short tail: LR=1, WIDTH=1280, BURSTR=7 -> 45 bursts of 7 then one burst wlen=5; addresses contiguous.
//  4 Backpressure: wrdy random 30%, src_str_val random 50% -> memory matches reference image,
//   wlen/waddr never change mid-burst, no pixel lost or duplicated.
//  5 Abort: clear CR bit0 mid-frame during a burst -> that burst completes, no further wval, irq stays 0;
//   restart with CR=1 completes new frame correctly.
//  6 Reset mid-burst: assert rst_n during BURST -> wval=0 immediately, FIFO empty, regs cleared.

Source files
------------

// File: rtl/stream_dma_write_pkg.sv
// Shared definitions for the frame-write DMA:
// register map, control bit positions and FSM states.
package stream_dma_write_pkg;

    localparam int REG_IDR    = 0;
    localparam int REG_CR     = 1;
    localparam int REG_SR     = 2;
    localparam int REG_DA     = 3;
    localparam int REG_LR     = 4;
    localparam int REG_BURSTR = 5;

    localparam int CR_EN   = 0;
    localparam int SR_DONE = 0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        DONE
    } state_t;

endpackage

// File: rtl/xlib_sync_fifo.sv
// Synchronous first-word fall-through FIFO with
// occupancy count and synchronous flush.
module xlib_sync_fifo #(
    parameter int W  = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0] mem [2**AW];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (AW+1)'(2**AW));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // storage write; contents need no reset
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    // pointer update; flush discards everything held
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/stream_dma_write.sv
// Frame-write DMA: packs pixels into words, queues them
// and writes them out as bursts; irq on frame completion.
module stream_dma_write
    import stream_dma_write_pkg::*;
#(
    parameter int          WIDTH   = 1280,
    parameter int          PW      = 8,
    parameter int          AW      = 32,
    parameter int          DW      = 32,
    parameter int          BL      = 4,
    parameter int          FIFO_AW = 5,
    parameter int          APB_AW  = 5,
    parameter logic [31:0] ID      = 32'hCE6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpb_r,
    input  logic              cpb_w,
    input  logic [APB_AW-1:0] cpb_a,
    input  logic [31:0]       cpb_d,
    output logic [31:0]       cpb_q,
    output logic              irq,
    output logic              src_str_rdy,
    input  logic              src_str_val,
    input  logic [PW-1:0]     src_str_d,
    input  logic              dst_bus_wrdy,
    output logic              dst_bus_wval,
    output logic [BL-1:0]     dst_bus_wlen,
    output logic [AW-1:0]     dst_bus_waddr,
    output logic [DW-1:0]     dst_bus_wdata
);

    localparam int PPW = DW / PW;
    localparam int PIW = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int WPL = WIDTH * PW / DW;

    state_t state, state_nx;

    logic           cr_en, sr_done;
    logic [AW-1:0]  da;
    logic [31:0]    lr;
    logic [BL-1:0]  burstr;

    logic [AW-1:0]  cur_addr;
    logic [31:0]    words_left, pack_left, t_words, left_after;
    logic [BL-1:0]  burst_len, blen_q, beat_cnt, n;

    logic [PIW-1:0] pix_idx;
    logic [DW-1:0]  word_q, word_nx;

    logic           fifo_full, fifo_empty;
    logic [FIFO_AW:0] fifo_count;
    logic [DW-1:0]  fifo_dout;

    logic wr_cr, wr_sr, start, busy, beat, last_beat;
    logic accept, pix_last, push, set_done, flush;
    logic unused_ok;

    assign unused_ok  = cpb_r;
    assign wr_cr      = cpb_w && cpb_a == APB_AW'(REG_CR);
    assign wr_sr      = cpb_w && cpb_a == APB_AW'(REG_SR);
    assign start      = wr_cr && cpb_d[CR_EN] && state == IDLE;
    assign busy       = state == WAIT || state == BURST;
    assign t_words    = lr * 32'(WPL);
    assign n          = (words_left < 32'(burst_len)) ?
                        words_left[BL-1:0] : burst_len;
    assign beat       = state == BURST && dst_bus_wrdy;
    assign last_beat  = beat && beat_cnt == blen_q - 1'b1;
    assign left_after = words_left - 32'(blen_q);

    assign src_str_rdy = busy && !fifo_full && pack_left != '0;
    assign accept      = src_str_val && src_str_rdy;
    assign pix_last    = pix_idx == PIW'(PPW - 1);
    assign push        = accept && pix_last;

    assign irq           = sr_done;
    assign dst_bus_wval  = state == BURST;
    assign dst_bus_wlen  = dst_bus_wval ? blen_q : '0;
    assign dst_bus_waddr = dst_bus_wval ? cur_addr : '0;
    assign dst_bus_wdata = dst_bus_wval ? fifo_dout : '0;

    xlib_sync_fifo #(
        .W  (DW),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .din   (word_nx),
        .pop   (beat),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // register read mux
    always_comb begin
        cpb_q = '0;
        case (cpb_a)
            APB_AW'(REG_IDR):    cpb_q = ID;
            APB_AW'(REG_CR):     cpb_q = 32'(cr_en);
            APB_AW'(REG_SR):     cpb_q = 32'(sr_done);
            APB_AW'(REG_DA):     cpb_q = 32'(da);
            APB_AW'(REG_LR):     cpb_q = lr;
            APB_AW'(REG_BURSTR): cpb_q = 32'(burstr);
            default:             cpb_q = '0;
        endcase
    end

    // CPU registers; a completing frame beats a DONE clear
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cr_en   <= 1'b0;
            sr_done <= 1'b0;
            da      <= '0;
            lr      <= '0;
            burstr  <= '0;
        end else begin
            if (wr_cr)
                cr_en <= cpb_d[CR_EN];
            if (set_done)
                sr_done <= 1'b1;
            else if (wr_sr && cpb_d[SR_DONE])
                sr_done <= 1'b0;
            if (cpb_w && cpb_a == APB_AW'(REG_DA))
                da <= cpb_d[AW-1:0];
            if (cpb_w && cpb_a == APB_AW'(REG_LR))
                lr <= cpb_d;
            if (cpb_w && cpb_a == APB_AW'(REG_BURSTR))
                burstr <= cpb_d[BL-1:0];
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // next state; an abort only takes effect between bursts
    always_comb begin
        state_nx = state;
        set_done = 1'b0;
        flush    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && t_words == '0) begin
                    state_nx = DONE;
                    set_done = 1'b1;
                end else if (start) begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (!cr_en) begin
                    flush    = 1'b1;
                    state_nx = IDLE;
                end else if (fifo_count >= (FIFO_AW+1)'(n)) begin
                    state_nx = BURST;
                end
            end
            BURST: begin
                if (last_beat && !cr_en) begin
                    flush    = 1'b1;
                    state_nx = IDLE;
                end else if (last_beat && left_after == '0) begin
                    set_done = 1'b1;
                    state_nx = DONE;
                end else if (last_beat) begin
                    state_nx = WAIT;
                end
            end
            DONE: state_nx = IDLE;
        endcase
    end

    // transfer working registers and burst counters
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cur_addr   <= '0;
            words_left <= '0;
            burst_len  <= '0;
            blen_q     <= '0;
            beat_cnt   <= '0;
        end else begin
            if (start) begin
                cur_addr   <= da;
                words_left <= t_words;
                burst_len  <= (burstr == '0) ? BL'(1) : burstr;
            end
            if (state == WAIT && state_nx == BURST) begin
                blen_q   <= n;
                beat_cnt <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (last_beat) begin
                cur_addr   <= cur_addr + AW'(blen_q);
                words_left <= left_after;
            end
        end
    end

    // incoming pixel dropped into its lane of the word
    always_comb begin
        word_nx = word_q;
        for (int k = 0; k < PPW; k++)
            if (pix_idx == PIW'(k))
                word_nx[k*PW +: PW] = src_str_d;
    end

    // packer: lane index and words still to be built
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            pix_idx   <= '0;
            pack_left <= '0;
            word_q    <= '0;
        end else if (flush) begin
            pix_idx   <= '0;
            pack_left <= '0;
            word_q    <= '0;
        end else if (start) begin
            pix_idx   <= '0;
            pack_left <= t_words;
        end else if (accept) begin
            word_q <= word_nx;
            if (pix_last) begin
                pix_idx   <= '0;
                pack_left <= pack_left - 1'b1;
            end else begin
                pix_idx <= pix_idx + 1'b1;
            end
        end
    end

endmodule
